// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state encoding and timing defaults for counter_ctrl
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ           = 12_000_000;
  localparam int unsigned DEFAULT_PRESCALE = CLK_HZ;
  localparam int unsigned DEFAULT_DEBOUNCE = 240_000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_ctrl_btn_debounce.sv
// rtl/counter_ctrl_btn_debounce.sv - button synchroniser, debouncer and press pulse
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Only a level that stays different from the stable one long enough is accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - button-driven control front-end for the loadable counter
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE        = DEFAULT_PRESCALE,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned DAT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_run,
  input  logic             btn_load,
  input  logic             btn_clr,
  input  logic [DAT_W-1:0] sw,
  output logic             en,
  output logic             ld,
  output logic [DAT_W-1:0] dat_in,
  output logic             cnt_rst,
  output logic             running
);

  localparam int unsigned PW = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic press_run, press_load, press_clr;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_run), .press_o(press_run)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_load), .press_o(press_load)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_clr), .press_o(press_clr)
  );

  logic [DAT_W-1:0] sw1_q, sw2_q;
  state_e           state_q, state_d;
  logic             ret_q, ret_d;
  logic [PW-1:0]    pre_q, pre_d, pre_inc;
  logic             tick;
  logic             en_q, en_d, ld_q, ld_d, rst_q, rst_d, run_q, run_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             do_clr, do_load, do_run;

  assign do_clr  = press_clr;
  assign do_load = press_load & ~press_clr;
  assign do_run  = press_run & ~press_load & ~press_clr;
  assign tick    = (pre_q == PRE_LAST);
  assign pre_inc = tick ? '0 : pre_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    pre_d   = pre_q;
    en_d    = 1'b0;
    ld_d    = 1'b0;
    rst_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      ST_STOP, ST_RUN: begin
        if (do_clr) begin
          rst_d = 1'b1;
          pre_d = '0;
        end else if (do_load) begin
          // A tick landing on the press cycle is absorbed by the load strobe.
          state_d = ST_LOAD;
          ret_d   = (state_q == ST_RUN);
          en_d    = 1'b1;
          ld_d    = 1'b1;
          dat_d   = sw2_q;
          pre_d   = (state_q == ST_RUN) ? pre_inc : '0;
        end else if (do_run) begin
          state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
          pre_d   = '0;
        end else if (state_q == ST_RUN) begin
          pre_d = pre_inc;
          en_d  = tick;
        end else begin
          pre_d = '0;
        end
      end
      ST_LOAD: begin
        state_d = ret_q ? ST_RUN : ST_STOP;
      end
      default: begin
        state_d = ST_STOP;
        pre_d   = '0;
      end
    endcase
    run_d = (state_d == ST_RUN) || ((state_d == ST_LOAD) && ret_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw1_q   <= '0;
      sw2_q   <= '0;
      state_q <= ST_STOP;
      ret_q   <= 1'b0;
      pre_q   <= '0;
      en_q    <= 1'b0;
      ld_q    <= 1'b0;
      dat_q   <= '0;
      rst_q   <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      sw1_q   <= sw;
      sw2_q   <= sw1_q;
      state_q <= state_d;
      ret_q   <= ret_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      ld_q    <= ld_d;
      dat_q   <= dat_d;
      rst_q   <= rst_d;
      run_q   <= run_d;
    end
  end

  assign en      = en_q;
  assign ld      = ld_q;
  assign dat_in  = dat_q;
  assign cnt_rst = rst_q;
  assign running = run_q;

endmodule
